instr_buffer: RTL and testbench

- Decoupling queue between the instruction fetcher and the decode stage.
- Accepts fetched_instr_t entries from the fetcher via a valid/ready handshake and presents them in order to decode.
- Absorbs decode stalls so the fetcher keeps issuing cache requests.
- Discards all buffered entries on a pipeline flush (branch mispredict, exception, fence.i redirect).

---
 rtl/muntjac_pkg.sv | 34 +++
 rtl/instr_buffer.sv | 89 ++++++++
 tb/tb_instr_buffer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muntjac_pkg.sv
// Shared front-end types: fetched instruction bundle, fetch reason, exceptions.
// Fetcher, instruction buffer and decode all exchange fetched_instr_t.
package muntjac_pkg;

    typedef enum logic [2:0] {
        IF_PREFETCH,
        IF_PREDICT,
        IF_MISPREDICT,
        IF_PROT_CHANGED,
        IF_SATP_CHANGED,
        IF_FENCE_I
    } if_reason_e;

    typedef enum logic [3:0] {
        EXC_INSTR_MISALIGN = 4'd0,
        EXC_INSTR_ACCESS   = 4'd1,
        EXC_ILLEGAL_INSTR  = 4'd2,
        EXC_INSTR_PAGE     = 4'd12
    } exc_cause_e;

    typedef struct packed {
        exc_cause_e  cause;
        logic [63:0] tval;
    } exception_t;

    typedef struct packed {
        logic [31:0] instr_word;
        logic [63:0] pc;
        if_reason_e  if_reason;
        logic        ex_valid;
        exception_t  exception;
    } fetched_instr_t;

endpackage

// File: rtl/instr_buffer.sv
// Instruction buffer: in-order queue between fetcher and decode.
// Ports: clk, resetn (async low); in_valid/in_ready/in_instr from fetcher;
//        out_valid/out_ready/out_instr to decode; flush drops all entries;
//        count is current occupancy (0..DEPTH).
module instr_buffer
    import muntjac_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  fetched_instr_t   in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output fetched_instr_t   out_instr,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetched_instr_t   mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             enq;
    logic             deq;

    assign full      = (cnt == CNT_W'(DEPTH));
    // A full buffer still accepts when the head leaves in the same cycle.
    assign in_ready  = !flush && (!full || out_ready);
    assign out_valid = (cnt != '0);
    assign out_instr = mem[rd_ptr];
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    assign count     = cnt;

    // Entry storage is never reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            cnt    <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({enq, deq})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_count_range: assert property (
        @(posedge clk) disable iff (!resetn)
        cnt <= CNT_W'(DEPTH)
    );

    a_no_enq_blocked: assert property (
        @(posedge clk) disable iff (!resetn)
        !in_ready |-> !enq
    );

    a_in_stable: assert property (
        @(posedge clk) disable iff (!resetn)
        (in_valid && !in_ready && !flush) |=> (flush || $stable(in_instr))
    );
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Bench for instr_buffer: queue model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_instr_buffer;
    import muntjac_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IW    = $bits(fetched_instr_t);

    logic             clk;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    fetched_instr_t   in_instr;
    logic             out_valid;
    logic             out_ready;
    fetched_instr_t   out_instr;
    logic             flush;
    logic [CNT_W-1:0] count;

    int checks   = 0;
    int failures = 0;

    fetched_instr_t model [$];
    logic [63:0]    out_log [$];

    instr_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [IW-1:0] act,
                       input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic fetched_instr_t mk(input logic [63:0] pc,
                                          input if_reason_e r);
        fetched_instr_t e;
        e.instr_word      = 32'h0000_0013 ^ pc[31:0];
        e.pc              = pc;
        e.if_reason       = r;
        e.ex_valid        = pc[2];
        e.exception.cause = pc[2] ? EXC_INSTR_PAGE : EXC_INSTR_MISALIGN;
        e.exception.tval  = ~pc;
        return e;
    endfunction

    // Queue model: outputs compared before the edge, then the edge applied.
    always @(negedge clk) begin
        logic exp_rdy;
        logic m_enq;
        logic m_deq;
        if (!resetn) model.delete();
        exp_rdy = !flush && (model.size() != DEPTH || out_ready);
        chk("in_ready", IW'(in_ready), IW'(exp_rdy));
        chk("out_valid", IW'(out_valid), IW'(model.size() != 0));
        chk("count", IW'(count), IW'(model.size()));
        if (model.size() != 0) chk("out_instr", out_instr, model[0]);
        if (resetn) begin
            if (flush) begin
                model.delete();
            end else begin
                m_deq = (model.size() != 0) && out_ready;
                m_enq = in_valid && exp_rdy;
                if (m_deq) begin
                    out_log.push_back(out_instr.pc);
                    void'(model.pop_front());
                end
                if (m_enq) model.push_back(in_instr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input fetched_instr_t e);
        int  n   = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_instr = e;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("push_accepted", IW'(acc), IW'(1));
    endtask

    task automatic check_log(input string nm, input logic [63:0] exp [$]);
        chk({nm, "_len"}, IW'(out_log.size()), IW'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < out_log.size()) chk(nm, IW'(out_log[i]), IW'(exp[i]));
        end
    endtask

    initial begin
        fetched_instr_t vec [10];
        int idx;
        int n;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        step();
        step();
        resetn = 1'b1;
        chk("rst_in_ready", IW'(in_ready), IW'(1));
        chk("rst_out_valid", IW'(out_valid), IW'(0));
        chk("rst_count", IW'(count), IW'(0));

        // Fill then drain
        out_log.delete();
        push(mk(64'h0, IF_PREFETCH));
        push(mk(64'h4, IF_PREFETCH));
        push(mk(64'h8, IF_PREFETCH));
        push(mk(64'hC, IF_PREFETCH));
        chk("fill_count", IW'(count), IW'(4));
        chk("fill_in_ready", IW'(in_ready), IW'(0));
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        check_log("drain_pc", '{64'h0, 64'h4, 64'h8, 64'hC});
        chk("drain_count", IW'(count), IW'(0));
        chk("drain_out_valid", IW'(out_valid), IW'(0));

        // Latency: no same-cycle bypass
        in_valid = 1'b1;
        in_instr = mk(64'h100, IF_PREDICT);
        #1;
        chk("lat_no_bypass", IW'(out_valid), IW'(0));
        step();
        in_valid = 1'b0;
        chk("lat_out_valid", IW'(out_valid), IW'(1));
        chk("lat_pc", IW'(out_instr.pc), IW'(64'h100));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Full with simultaneous enqueue and dequeue
        push(mk(64'h10, IF_PREFETCH));
        push(mk(64'h14, IF_PREFETCH));
        push(mk(64'h18, IF_PREFETCH));
        push(mk(64'h1C, IF_PREFETCH));
        out_log.delete();
        in_valid  = 1'b1;
        in_instr  = mk(64'h20, IF_PREFETCH);
        out_ready = 1'b1;
        #1;
        chk("full_both_ready", IW'(in_ready), IW'(1));
        step();
        in_valid = 1'b0;
        chk("full_both_count", IW'(count), IW'(4));
        repeat (4) step();
        out_ready = 1'b0;
        check_log("full_pc",
                  '{64'h10, 64'h14, 64'h18, 64'h1C, 64'h20});

        // Flush mid-stream, then held flush
        push(mk(64'h40, IF_PREFETCH));
        push(mk(64'h44, IF_PREFETCH));
        push(mk(64'h48, IF_PREFETCH));
        chk("pre_flush_count", IW'(count), IW'(3));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = mk(64'h4C, IF_PREFETCH);
        #1;
        chk("flush_in_ready", IW'(in_ready), IW'(0));
        step();
        chk("flush_count", IW'(count), IW'(0));
        chk("flush_out_valid", IW'(out_valid), IW'(0));
        step();
        step();
        chk("flush_held_ready", IW'(in_ready), IW'(0));
        chk("flush_held_count", IW'(count), IW'(0));
        flush    = 1'b0;
        in_valid = 1'b0;
        push(mk(64'h80, IF_MISPREDICT));
        chk("redir_pc", IW'(out_instr.pc), IW'(64'h80));
        chk("redir_reason", IW'(out_instr.if_reason), IW'(IF_MISPREDICT));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Wrap-around with random decode stalls
        for (int i = 0; i < 10; i++) begin
            vec[i] = mk(64'h200 + 64'(4 * i), IF_PREFETCH);
        end
        out_log.delete();
        idx = 0;
        n   = 0;
        while ((idx < 10 || out_log.size() < 10) && n < 300) begin
            out_ready = (idx >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid  = (idx < 10);
            if (idx < 10) in_instr = vec[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("wrap_done", IW'(n < 300), IW'(1));
        check_log("wrap_pc",
                  '{64'h200, 64'h204, 64'h208, 64'h20C, 64'h210,
                    64'h214, 64'h218, 64'h21C, 64'h220, 64'h224});

        // Asynchronous reset between edges
        push(mk(64'h300, IF_PREFETCH));
        push(mk(64'h304, IF_PREFETCH));
        chk("pre_rst_count", IW'(count), IW'(2));
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_out_valid", IW'(out_valid), IW'(0));
        chk("arst_count", IW'(count), IW'(0));
        chk("arst_in_ready", IW'(in_ready), IW'(1));
        step();
        resetn = 1'b1;
        push(mk(64'h400, IF_FENCE_I));
        chk("post_rst_pc", IW'(out_instr.pc), IW'(64'h400));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
